// File: rtl/nclic_irq_gate.sv
// Per-source interrupt conditioning for the nclic arbiter: synchronises raw IRQ lines,
// tracks level or rising-edge pending state, and holds enable/trigger/priority config.
module nclic_irq_gate #(
    parameter int IntAmount = 8,
    parameter int IdxWidth  = 3,
    parameter int PrioWidth = 4
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [IntAmount-1:0]                i_irq,
    input  logic                                i_cfg_we,
    input  logic [IdxWidth-1:0]                 i_cfg_widx,
    input  logic [15:0]                         i_cfg_wdata,
    input  logic                                i_cfg_re,
    input  logic [IdxWidth-1:0]                 i_cfg_ridx,
    output logic [15:0]                         o_cfg_rdata,
    input  logic                                i_ack,
    input  logic [IdxWidth-1:0]                 i_ack_idx,
    output logic [IntAmount-1:0][PrioWidth-1:0] o_priorities,
    output logic [IntAmount-1:0]                o_pendings,
    output logic [IntAmount-1:0]                o_enables
);

    localparam logic [IdxWidth:0] AMT = (IdxWidth+1)'(IntAmount);

    logic [IntAmount-1:0]                s1_q, s2_q, s3_q;
    logic [IntAmount-1:0]                pend_q, pend_d;
    logic [IntAmount-1:0]                en_q, en_d;
    logic [IntAmount-1:0]                trig_q, trig_d;
    logic [IntAmount-1:0][PrioWidth-1:0] prio_q, prio_d;
    logic [15:0]                         rdata_q, rdata_d;

    logic wr_ok, rd_ok, ack_ok;
    logic unused_wdata;

    assign unused_wdata = ^{i_cfg_wdata[15:8+PrioWidth], i_cfg_wdata[7:3]};

    always_comb begin
        wr_ok  = i_cfg_we && ({1'b0, i_cfg_widx} < AMT);
        rd_ok  = {1'b0, i_cfg_ridx} < AMT;
        ack_ok = i_ack && ({1'b0, i_ack_idx} < AMT);

        pend_d = pend_q;
        en_d   = en_q;
        trig_d = trig_q;
        prio_d = prio_q;

        for (int i = 0; i < IntAmount; i++) begin
            logic wr_hit, ack_hit, trig_eff;
            wr_hit   = wr_ok && (i_cfg_widx == IdxWidth'(i));
            ack_hit  = ack_ok && (i_ack_idx == IdxWidth'(i));
            // The trigger mode being written takes effect for this cycle's pending update.
            trig_eff = wr_hit ? i_cfg_wdata[2] : trig_q[i];

            if (!trig_eff) begin
                pend_d[i] = s2_q[i];
            end else if (s2_q[i] && !s3_q[i]) begin
                pend_d[i] = 1'b1;
            end else if (wr_hit) begin
                pend_d[i] = i_cfg_wdata[0];
            end else if (ack_hit) begin
                pend_d[i] = 1'b0;
            end

            if (wr_hit) begin
                en_d[i]   = i_cfg_wdata[1];
                trig_d[i] = i_cfg_wdata[2];
                prio_d[i] = i_cfg_wdata[8 +: PrioWidth];
            end
        end

        rdata_d = '0;
        if (rd_ok) begin
            rdata_d[0]             = pend_q[i_cfg_ridx];
            rdata_d[1]             = en_q[i_cfg_ridx];
            rdata_d[2]             = trig_q[i_cfg_ridx];
            rdata_d[8 +: PrioWidth] = prio_q[i_cfg_ridx];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q    <= '0;
            s2_q    <= '0;
            s3_q    <= '0;
            pend_q  <= '0;
            en_q    <= '0;
            trig_q  <= '0;
            prio_q  <= '0;
            rdata_q <= '0;
        end else begin
            s1_q   <= i_irq;
            s2_q   <= s1_q;
            s3_q   <= s2_q;
            pend_q <= pend_d;
            en_q   <= en_d;
            trig_q <= trig_d;
            prio_q <= prio_d;
            if (i_cfg_re) begin
                rdata_q <= rdata_d;
            end
        end
    end

    assign o_pendings   = pend_q;
    assign o_enables    = en_q;
    assign o_priorities = prio_q;
    assign o_cfg_rdata  = rdata_q;

endmodule
